// File: rtl/reg_writeback_pkg.sv
// Shared types and constants for the register write-back block.
package reg_writeback_pkg;

  localparam int REG_AW      = 5;
  localparam int XLEN        = 32;
  localparam int UPPER_SHIFT = 16;

  // One register-file write request as presented on the wb_* port.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
    logic              upper;
  } wb_req_t;

  // One buffered load response.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } lq_entry_t;

  // Value the register file will actually hold after an upper-immediate write.
  function automatic logic [XLEN-1:0] shift_upper(input logic [XLEN-1:0] d,
                                                  input logic            up);
    return up ? {d[XLEN-UPPER_SHIFT-1:0], {UPPER_SHIFT{1'b0}}} : d;
  endfunction

endpackage

// File: rtl/reg_wb_lq.sv
// Load-response queue: circular FIFO of {rd, data} with pointer pair and count.
module reg_wb_lq
  import reg_writeback_pkg::*;
#(
  parameter int LQ_DEPTH = 4,
  parameter int LQ_AW    = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_valid,
  output logic      push_ready,
  input  lq_entry_t push_entry,
  input  logic      pop,
  output logic      empty,
  output lq_entry_t head
);

  localparam logic [LQ_AW:0] FULL_CNT = (LQ_AW+1)'(LQ_DEPTH);

  logic [LQ_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LQ_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LQ_AW:0]   count_q, count_d;
  lq_entry_t        mem_q [LQ_DEPTH];
  logic             push_fire, pop_fire;

  // Ready and empty come only from registered count, never from push_valid.
  always_comb begin
    push_ready = (count_q != FULL_CNT);
    empty      = (count_q == '0);
    push_fire  = push_valid & push_ready;
    pop_fire   = pop & ~empty;
    head       = mem_q[rd_ptr_q];
  end

  // Next-state pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_fire) wr_ptr_d = wr_ptr_q + LQ_AW'(1);
    if (pop_fire)  rd_ptr_d = rd_ptr_q + LQ_AW'(1);
    case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + (LQ_AW+1)'(1);
      2'b01:   count_d = count_q - (LQ_AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count state; reset discards all queued entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_fire) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write-port master: ALU/load arbitration, load scoreboard,
// decode stall and optional forwarding. Optional feature macro: WB_BYPASS_EN
// (defined: in-flight write is forwarded; undefined: it stalls decode instead).
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int LQ_DEPTH = 4,
  parameter int LQ_AW    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              alu_upper,
  input  logic              ld_issue_valid,
  input  logic [REG_AW-1:0] ld_issue_rd,
  input  logic              ld_resp_valid,
  output logic              ld_resp_ready,
  input  logic [REG_AW-1:0] ld_resp_rd,
  input  logic [XLEN-1:0]   ld_resp_data,
  input  logic [REG_AW-1:0] q_rs0,
  input  logic [REG_AW-1:0] q_rs1,
  input  logic [REG_AW-1:0] q_rd,
  output logic              stall,
  output logic [REG_AW-1:0] wb_waddr,
  output logic [XLEN-1:0]   wb_wdata,
  output logic              wb_wren,
  output logic              wb_is_upper,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_addr,
  output logic [XLEN-1:0]   fwd_data
);

  // Load responses use valid/ready: a response transfers on a rising clk edge
  // where ld_resp_valid & ld_resp_ready; the source holds rd/data stable while
  // valid is high and not yet accepted. ALU results have no backpressure.

  lq_entry_t resp_entry, lq_head;
  logic      lq_empty, lq_pop;
  wb_req_t   wb_q, wb_d;
  logic      wb_wren_q, wb_wren_d;
  logic [31:0] pending_q, pending_d;
  logic      stall_sb;

  assign resp_entry.rd   = ld_resp_rd;
  assign resp_entry.data = ld_resp_data;

  reg_wb_lq #(
    .LQ_DEPTH (LQ_DEPTH),
    .LQ_AW    (LQ_AW)
  ) u_lq (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (ld_resp_valid),
    .push_ready (ld_resp_ready),
    .push_entry (resp_entry),
    .pop        (lq_pop),
    .empty      (lq_empty),
    .head       (lq_head)
  );

  // Arbitrate the write port: ALU first, else drain one queued load; x0 never written.
  always_comb begin
    wb_d      = wb_q;
    wb_wren_d = 1'b0;
    lq_pop    = 1'b0;
    if (alu_valid) begin
      wb_d.rd    = alu_rd;
      wb_d.data  = alu_data;
      wb_d.upper = alu_upper;
      wb_wren_d  = (alu_rd != '0);
    end else if (!lq_empty) begin
      lq_pop     = 1'b1;
      wb_d.rd    = lq_head.rd;
      wb_d.data  = lq_head.data;
      wb_d.upper = 1'b0;
      wb_wren_d  = (lq_head.rd != '0);
    end
  end

  // Scoreboard update: a pop clears its rd, a same-cycle issue to that rd re-sets it.
  always_comb begin
    pending_d = pending_q;
    if (lq_pop) pending_d[lq_head.rd] = 1'b0;
    if (ld_issue_valid && (ld_issue_rd != '0)) pending_d[ld_issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Registered write port and scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q      <= '0;
      wb_wren_q <= 1'b0;
      pending_q <= '0;
    end else begin
      wb_q      <= wb_d;
      wb_wren_q <= wb_wren_d;
      pending_q <= pending_d;
    end
  end

  assign wb_waddr    = wb_q.rd;
  assign wb_wdata    = wb_q.data;
  assign wb_wren     = wb_wren_q;
  assign wb_is_upper = wb_q.upper;

  // Decode stall from outstanding loads (RAW on sources, WAW on destination).
  always_comb begin
    stall_sb = ((q_rs0 != '0) & pending_q[q_rs0]) |
               ((q_rs1 != '0) & pending_q[q_rs1]) |
               ((q_rd  != '0) & pending_q[q_rd]);
  end

`ifdef WB_BYPASS_EN
  // In-flight write is forwarded to decode, so it never causes a stall.
  always_comb begin
    stall     = stall_sb;
    fwd_valid = wb_wren_q;
    fwd_addr  = wb_q.rd;
    fwd_data  = shift_upper(wb_q.data, wb_q.upper);
  end
`else
  // Without forwarding, a source being written this cycle is not yet readable.
  always_comb begin
    stall     = stall_sb |
                (wb_wren_q & (wb_q.rd != '0) &
                 ((wb_q.rd == q_rs0) | (wb_q.rd == q_rs1)));
    fwd_valid = 1'b0;
    fwd_addr  = '0;
    fwd_data  = '0;
  end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed vectors, expected writes queued by the
// drivers and checked by an independent write-port monitor.
module tb_reg_writeback;

  localparam int LQ_DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_upper;
  logic        ld_issue_valid;
  logic [4:0]  ld_issue_rd;
  logic        ld_resp_valid;
  logic        ld_resp_ready;
  logic [4:0]  ld_resp_rd;
  logic [31:0] ld_resp_data;
  logic [4:0]  q_rs0, q_rs1, q_rd;
  logic        stall;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_wren;
  logic        wb_is_upper;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;

  // {rd, data, upper} of each write expected on the port, in order
  logic [37:0] exp_q[$];
  // {rd, data} of load responses accepted but not yet written
  logic [36:0] lq_model[$];

  int checks = 0;
  int errors = 0;
  logic last_acc;

  reg_writeback #(.LQ_DEPTH(LQ_DEPTH), .LQ_AW(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .alu_upper      (alu_upper),
    .ld_issue_valid (ld_issue_valid),
    .ld_issue_rd    (ld_issue_rd),
    .ld_resp_valid  (ld_resp_valid),
    .ld_resp_ready  (ld_resp_ready),
    .ld_resp_rd     (ld_resp_rd),
    .ld_resp_data   (ld_resp_data),
    .q_rs0          (q_rs0),
    .q_rs1          (q_rs1),
    .q_rd           (q_rd),
    .stall          (stall),
    .wb_waddr       (wb_waddr),
    .wb_wdata       (wb_wdata),
    .wb_wren        (wb_wren),
    .wb_is_upper    (wb_is_upper),
    .fwd_valid      (fwd_valid),
    .fwd_addr       (fwd_addr),
    .fwd_data       (fwd_data)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: check handshake against the queue model, predict this cycle's
  // port winner, record acceptance, then advance to just after the edge.
  task automatic cycle();
    logic        model_ready;
    logic        acc;
    logic [36:0] e;
    model_ready = (lq_model.size() != LQ_DEPTH);
    check("ld_resp_ready", 32'(ld_resp_ready), 32'(model_ready));
    acc = ld_resp_valid && model_ready;
    if (alu_valid) begin
      if (alu_rd != 5'd0) exp_q.push_back({alu_rd, alu_data, alu_upper});
    end else if (lq_model.size() != 0) begin
      e = lq_model.pop_front();
      if (e[36:32] != 5'd0) exp_q.push_back({e, 1'b0});
    end
    if (acc) lq_model.push_back({ld_resp_rd, ld_resp_data});
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic check_stall(input string name, input logic [4:0] rs0, input logic [4:0] rs1,
                             input logic [4:0] rd, input logic exp);
    q_rs0 = rs0; q_rs1 = rs1; q_rd = rd;
    #1;
    check(name, 32'(stall), 32'(exp));
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0; alu_upper = 0;
    ld_issue_valid = 0; ld_issue_rd = 0;
    ld_resp_valid = 0; ld_resp_rd = 0; ld_resp_data = 0;
    q_rs0 = 0; q_rs1 = 0; q_rd = 0;
  endtask

  // Monitor: every visible write must match the head of the expected queue.
  always @(negedge clk) begin
    logic [37:0] e;
    if (rst_n && wb_wren) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%h/%h expected=none t=%0t", wb_waddr, wb_wdata, $time);
      end else begin
        e = exp_q.pop_front();
        check("wb_waddr", 32'(wb_waddr), 32'(e[37:33]));
        check("wb_wdata", wb_wdata, e[32:1]);
        check("wb_is_upper", 32'(wb_is_upper), 32'(e[0]));
`ifdef WB_BYPASS_EN
        check("fwd_valid", 32'(fwd_valid), 32'd1);
        check("fwd_addr", 32'(fwd_addr), 32'(e[37:33]));
        check("fwd_data", fwd_data, e[0] ? {e[16:1], 16'h0} : e[32:1]);
`else
        check("fwd_valid_tied", 32'(fwd_valid), 32'd0);
        check("fwd_data_tied", fwd_data, 32'd0);
`endif
      end
    end
  end

  initial begin
    int ld_idx;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check("rst_wb_wren", 32'(wb_wren), 32'd0);
    check("rst_wb_waddr", 32'(wb_waddr), 32'd0);
    check("rst_wb_wdata", wb_wdata, 32'd0);
    check("rst_wb_is_upper", 32'(wb_is_upper), 32'd0);
    check("rst_ready", 32'(ld_resp_ready), 32'd1);
    check("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    check_stall("rst_stall", 5'd1, 5'd31, 5'd5, 1'b0);
    q_rs0 = 0; q_rs1 = 0; q_rd = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: ALU upper-immediate write
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h0000_1234; alu_upper = 1;
    cycle();
    alu_valid = 0; alu_upper = 0;
    cycle();

    // 2: load scoreboard, stall, response and clear
    ld_issue_valid = 1; ld_issue_rd = 5'd5;
    cycle();
    ld_issue_valid = 0;
    check_stall("t2_rs0_pending", 5'd5, 5'd0, 5'd0, 1'b1);
    check_stall("t2_rd_pending", 5'd0, 5'd0, 5'd5, 1'b1);
    check_stall("t2_other_reg", 5'd4, 5'd6, 5'd0, 1'b0);
    ld_resp_valid = 1; ld_resp_rd = 5'd5; ld_resp_data = 32'hDEAD_BEEF;
    cycle();
    ld_resp_valid = 0;
    check_stall("t2_rs1_queued", 5'd0, 5'd5, 5'd0, 1'b1);
    cycle();
    // write to x5 is on the port this cycle
`ifdef WB_BYPASS_EN
    check_stall("t2_inflight_bypass", 5'd5, 5'd0, 5'd0, 1'b0);
`else
    check_stall("t2_inflight_nobypass", 5'd5, 5'd0, 5'd0, 1'b1);
`endif
    cycle();
    check_stall("t2_after_write", 5'd5, 5'd0, 5'd0, 1'b0);
    q_rs0 = 0;

    // 3: ALU burst starving the port while loads fill the queue
    ld_idx = 0;
    for (int c = 0; c < 12; c++) begin
      alu_valid = (c < 6); alu_rd = 5'(10 + c); alu_data = 32'hA000_0000 + c; alu_upper = 0;
      ld_resp_valid = (ld_idx < 5);
      ld_resp_rd = 5'(20 + ld_idx); ld_resp_data = 32'hB000_0000 + ld_idx;
      cycle();
      if (last_acc) ld_idx++;
    end
    alu_valid = 0; ld_resp_valid = 0;
    check("t3_loads_accepted", 32'(ld_idx), 32'd5);

    // 4: x0 destinations never write; load to x0 still drains
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    cycle();
    alu_valid = 0;
    ld_resp_valid = 1; ld_resp_rd = 5'd0; ld_resp_data = 32'h1111_1111;
    cycle();
    ld_resp_valid = 0;
    cycle();
    ld_issue_valid = 1; ld_issue_rd = 5'd0;
    cycle();
    ld_issue_valid = 0;
    cycle();
    check("t4_queue_drained_ready", 32'(ld_resp_ready), 32'd1);
    check_stall("t4_x0_query", 5'd0, 5'd0, 5'd0, 1'b0);

    // 5: issue and pop to the same rd in one cycle -> stays pending
    ld_issue_valid = 1; ld_issue_rd = 5'd7;
    cycle();
    ld_issue_valid = 0;
    ld_resp_valid = 1; ld_resp_rd = 5'd7; ld_resp_data = 32'h0000_0077;
    cycle();
    ld_resp_valid = 0;
    ld_issue_valid = 1; ld_issue_rd = 5'd7;
    cycle();
    ld_issue_valid = 0;
    cycle();
    check_stall("t5_set_wins", 5'd7, 5'd0, 5'd0, 1'b1);
    q_rs0 = 0;

    // 6: reset in the middle of a burst with queued loads
    for (int i = 0; i < 3; i++) begin
      ld_issue_valid = 1; ld_issue_rd = 5'(8 + i);
      cycle();
    end
    ld_issue_valid = 0;
    for (int c = 0; c < 5; c++) begin
      alu_valid = 1; alu_rd = 5'(11 + c); alu_data = 32'hC000_0000 + c;
      ld_resp_valid = (c < 3); ld_resp_rd = 5'(8 + c); ld_resp_data = 32'hD000_0000 + c;
      cycle();
    end
    alu_valid = 0; ld_resp_valid = 0;
    rst_n = 1'b0;
    exp_q.delete();
    lq_model.delete();
    #1;
    check("t6_wren_drop", 32'(wb_wren), 32'd0);
    check("t6_ready_in_reset", 32'(ld_resp_ready), 32'd1);
    check_stall("t6_stall_in_reset", 5'd8, 5'd9, 5'd10, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_ready_after", 32'(ld_resp_ready), 32'd1);
    check_stall("t6_stall_after_a", 5'd8, 5'd9, 5'd10, 1'b0);
    check_stall("t6_stall_after_b", 5'd7, 5'd5, 5'd3, 1'b0);
    q_rs0 = 0; q_rs1 = 0; q_rd = 0;
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h0000_0055; alu_upper = 0;
    cycle();
    alu_valid = 0;

    // drain, bounded
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      cycle();
    end
    @(posedge clk); #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("lq_model_drained", 32'(lq_model.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
